iter_divider: RTL and testbench

ITER_DIVIDER -- requirements
Module: iter_divider

---
 rtl/div_pkg.sv | 18 +
 rtl/div_step.sv | 27 ++
 rtl/iter_divider.sv | 153 +++++++++++++++
 tb/tb_iter_divider.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared constants and state encoding for the iterative divider.
package div_pkg;

    localparam int DIV_WIDTH = 32;
    // One restoring step per result bit.
    localparam int DIV_ITERS = DIV_WIDTH;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic int cnt_bits(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-compare-subtract step on magnitudes (purely combinational).
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             borrow;

    always_comb begin
        shifted = {rem_in, quo_in[WIDTH-1]};
        diff    = shifted - {2'b00, divisor};
        borrow  = diff[WIDTH+1];
        // A borrow means the divisor did not fit: restore the shifted value.
        rem_out = borrow ? shifted[WIDTH:0] : diff[WIDTH:0];
        quo_out = {quo_in[WIDTH-2:0], ~borrow};
    end

endmodule

// File: rtl/iter_divider.sv
// Fixed-latency signed/unsigned iterative divider (FSM, operand registers, sign fix-up).
// Optional macro DIV_ZERO_FAST_EN adds a div_zero output and a one-cycle divide-by-zero path.
module iter_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
`ifdef DIV_ZERO_FAST_EN
    ,
    output logic             div_zero
`endif
);

    localparam int                CNT_W    = cnt_bits(WIDTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_zero_q, div_zero_d;

    logic [WIDTH:0]   step_rem;
    logic [WIDTH-1:0] step_quo;
    logic             a_neg, b_neg;
    logic [WIDTH-1:0] mag_a, mag_b;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .quo_in  (quo_q),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    always_comb begin
        // NOTE: every signal gets a default first so no branch can infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        dvs_d       = dvs_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        div_zero_d  = 1'b0;

        a_neg = sign & dividend[WIDTH-1];
        b_neg = sign & divisor[WIDTH-1];
        mag_a = a_neg ? -dividend : dividend;
        mag_b = b_neg ? -divisor : divisor;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    cnt_d   = '0;
                    rem_d   = '0;
                    quo_d   = mag_a;
                    dvs_d   = mag_b;
                    // Divide-by-zero yields an all-ones quotient, so never negate it.
                    q_neg_d = (a_neg ^ b_neg) & (divisor != '0);
                    r_neg_d = a_neg;
                    state_d = RUN;
`ifdef DIV_ZERO_FAST_EN
                    if (divisor == '0) begin
                        quotient_d  = '1;
                        remainder_d = dividend;
                        div_zero_d  = 1'b1;
                        state_d     = DONE;
                    end
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_CNT) begin
                    quotient_d  = q_neg_q ? -step_quo : step_quo;
                    remainder_d = r_neg_q ? -step_rem[WIDTH-1:0] : step_rem[WIDTH-1:0];
                    state_d     = DONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            div_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            dvs_q       <= dvs_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            div_zero_q  <= div_zero_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quotient_q;
    assign remainder = remainder_q;
`ifdef DIV_ZERO_FAST_EN
    assign div_zero  = div_zero_q;
`else
    logic unused_div_zero;
    assign unused_div_zero = div_zero_q;
`endif

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider: vector table plus hand sequences for latency,
// start-in-RUN, back-to-back, reset abort and divide-by-zero (honours DIV_ZERO_FAST_EN).
module tb_iter_divider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        sign;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
`ifdef DIV_ZERO_FAST_EN
    logic        div_zero;
`endif

    iter_divider #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .sign      (sign),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
`ifdef DIV_ZERO_FAST_EN
        ,
        .div_zero  (div_zero)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        sg;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    vec_t        vecs [9];
    int          tests  = 0;
    int          fails  = 0;
    logic [31:0] last_q = '0;
    logic [31:0] last_r = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Entered #1 after an edge with start already driven; returns #1 after the edge
    // that begins the done cycle (cyc = -1 if done never came within the budget).
    task automatic wait_done(input int inject, output int cyc, output int busy_cnt,
                             output logic moved, output logic dz);
        cyc      = -1;
        busy_cnt = 0;
        moved    = 1'b0;
        dz       = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 1; k <= 100; k++) begin
            start = 1'b0;
            if (done) begin
                cyc = k;
`ifdef DIV_ZERO_FAST_EN
                dz = div_zero;
`endif
                break;
            end
            if (busy) busy_cnt++;
            if (quotient !== last_q || remainder !== last_r) moved = 1'b1;
            if (k == inject) begin
                start    = 1'b1;
                sign     = ~sign;
                dividend = 32'd55;
                divisor  = 32'd3;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic run_div(input logic sg, input logic [31:0] a, input logic [31:0] b,
                           input int inject, output int cyc, output int busy_cnt,
                           output logic moved, output logic dz);
        sign     = sg;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        wait_done(inject, cyc, busy_cnt, moved, dz);
    endtask

    task automatic check_result(input string name, input logic [31:0] exp_q,
                                input logic [31:0] exp_r, input int cyc, input int busy_cnt,
                                input logic moved, input int exp_cyc, input int exp_busy);
        check({name, " done_cycle"}, cyc, exp_cyc);
        check({name, " busy_cycles"}, busy_cnt, exp_busy);
        check({name, " held_during_run"}, moved, 1'b0);
        check({name, " quotient"}, quotient, exp_q);
        check({name, " remainder"}, remainder, exp_r);
        last_q = exp_q;
        last_r = exp_r;
    endtask

    task automatic idle_watch(input int n, output logic saw_done, output logic saw_busy);
        saw_done = 1'b0;
        saw_busy = 1'b0;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            saw_done |= done;
            saw_busy |= busy;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   cyc, bc, zc, zb;
        logic mv, dz, sd, sb;

        vecs[0] = '{"u_100_7",      1'b0, 32'd100,       32'd7,         32'h0000000E, 32'h00000002};
        vecs[1] = '{"s_m7_2",       1'b1, 32'hFFFFFFF9,  32'h00000002,  32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[2] = '{"s_min_m1",     1'b1, 32'h80000000,  32'hFFFFFFFF,  32'h80000000, 32'h00000000};
        vecs[3] = '{"u_max_1",      1'b0, 32'hFFFFFFFF,  32'h00000001,  32'hFFFFFFFF, 32'h00000000};
        vecs[4] = '{"s_7_m2",       1'b1, 32'h00000007,  32'hFFFFFFFE,  32'hFFFFFFFD, 32'h00000001};
        vecs[5] = '{"s_m7_m2",      1'b1, 32'hFFFFFFF9,  32'hFFFFFFFE,  32'h00000003, 32'hFFFFFFFF};
        vecs[6] = '{"u_fff9_2",     1'b0, 32'hFFFFFFF9,  32'h00000002,  32'h7FFFFFFC, 32'h00000001};
        vecs[7] = '{"u_5_9",        1'b0, 32'h00000005,  32'h00000009,  32'h00000000, 32'h00000005};
        vecs[8] = '{"u_min_m1",     1'b0, 32'h80000000,  32'hFFFFFFFF,  32'h00000000, 32'h80000000};

        reset    = 1'b1;
        start    = 1'b0;
        sign     = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset busy", busy, 1'b0);
        check("reset done", done, 1'b0);
        check("reset quotient", quotient, 32'h0);
        check("reset remainder", remainder, 32'h0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 9; i++) begin
            run_div(vecs[i].sg, vecs[i].a, vecs[i].b, 0, cyc, bc, mv, dz);
            check_result(vecs[i].name, vecs[i].q, vecs[i].r, cyc, bc, mv, 33, 32);
            @(posedge clk);
            #1;
        end

`ifdef DIV_ZERO_FAST_EN
        zc = 1;
        zb = 0;
`else
        zc = 33;
        zb = 32;
`endif
        run_div(1'b0, 32'h00001234, 32'h0, 0, cyc, bc, mv, dz);
        check_result("u_div0", 32'hFFFFFFFF, 32'h00001234, cyc, bc, mv, zc, zb);
`ifdef DIV_ZERO_FAST_EN
        check("u_div0 div_zero", dz, 1'b1);
`endif
        @(posedge clk);
        #1;
        run_div(1'b1, 32'hFFFFFFFB, 32'h0, 0, cyc, bc, mv, dz);
        check_result("s_div0", 32'hFFFFFFFF, 32'hFFFFFFFB, cyc, bc, mv, zc, zb);
        @(posedge clk);
        #1;

        // Start pulsed in RUN cycle 10 must not disturb the division in flight.
        run_div(1'b0, 32'd100, 32'd7, 10, cyc, bc, mv, dz);
        check_result("start_in_run", 32'h0000000E, 32'h00000002, cyc, bc, mv, 33, 32);

        // Start in the DONE cycle: back-to-back, second done 33 cycles later.
        run_div(1'b1, 32'hFFFFFFF9, 32'h00000002, 0, cyc, bc, mv, dz);
        check_result("back_to_back", 32'hFFFFFFFD, 32'hFFFFFFFF, cyc, bc, mv, 33, 32);

        idle_watch(5, sd, sb);
        check("hold quotient", quotient, last_q);
        check("hold remainder", remainder, last_r);
        check("hold no_done", sd, 1'b0);

        // Reset in RUN cycle 15 abandons the operation.
        sign     = 1'b0;
        dividend = 32'd1000;
        divisor  = 32'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (14) @(posedge clk);
        #1;
        check("abort busy_before", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        check("abort quotient", quotient, 32'h0);
        check("abort remainder", remainder, 32'h0);
        last_q = '0;
        last_r = '0;
        idle_watch(40, sd, sb);
        check("abort no_done", sd, 1'b0);
        check("abort no_busy", sb, 1'b0);

        // Reset and start on the same edge: reset wins.
        sign     = 1'b0;
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        reset    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        reset = 1'b0;
        check("reset_start busy", busy, 1'b0);
        idle_watch(36, sd, sb);
        check("reset_start no_done", sd, 1'b0);
        check("reset_start no_busy", sb, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
